conv1d_sequencer: RTL
=====================

# conv1d_sequencer

Multi-cycle controller that sequences a 1-D convolution (kernel length 8, "same" padding of 4) over the CFU's input and kernel word buffers. It issues buffer read addresses, performs a 4-lane int8 MAC per cycle, adds bias, and streams one 32-bit result per output position to the output buffer through a valid/ready write port. It sits between the CFU command decoder, which configures and starts it, and the buffer RAMs.

## Interface
- MAX_LEN, 1024: maximum sequence length (output positions).
- MAX_CH, 128: maximum input channels; buffers hold MAX_CH/4 words per row.
- KERNEL_LENGTH, 8: taps per channel; fixed at 8.
- PADDING, 4: left tap offset, so tap k reads row p+k-4.

- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- cfg_len  in  11  number of outputs; values > MAX_LEN are treated as MAX_LEN.
- cfg_ch  in  8  channels; groups G = cfg_ch>>2, low 2 bits ignored.
- cfg_bias  in  32  signed bias added per output.
- cfg_input_offset  in  9  signed, added to every input byte.
- busy  out  1  high from the first RUN cycle through WRITE.
- done  out  1  one-cycle pulse at completion.
- in_rd_en  out  1  input buffer read strobe.
- in_rd_addr  out  15  row*(MAX_CH/4)+g.
- in_rd_data  in  32  4 int8 lanes; [31:24] = channel 4g … [7:0] = channel 4g+3.
- k_rd_en  out  1  kernel buffer read strobe.
- k_rd_addr  out  8  k*(MAX_CH/4)+g.
- k_rd_data  in  32  4 int8 weights, same lane order.
- out_wr_valid  out  1  result valid.
- out_wr_ready  in  1  output buffer accepts.
- out_wr_addr  out  10  output position p.
- out_wr_data  out  32  signed result.

## Operation
- States: IDLE, RUN, DRAIN, WRITE, DONE.
- IDLE: start=1 captures all cfg_* into internal registers. If effective len=0 or G=0, go to DONE; otherwise go to RUN with p=0, k=0, g=0, accumulator=0.
- RUN: one read per cycle; k is the inner loop (0..7) and g is the outer loop (0..G-1). row = p+k-4. If 0 ≤ row < len, assert in_rd_en and k_rd_en; otherwise suppress both strobes and force that slot's product to 0. Every slot costs one cycle. After the last slot (k=7, g=G-1), go to DRAIN.
- DRAIN: 2 cycles for the pipeline to empty, then WRITE.
- WRITE: out_wr_valid=1, out_wr_addr=p, out_wr_data=acc+bias. On ready, clear the accumulator. If p=len-1, go to DONE; otherwise p++ and return to RUN.
- DONE: done=1 for one cycle, then IDLE.
- Arithmetic:
  - Lane product = (sext(in_byte)+offset) as signed 10-bit × signed 8-bit weight.
  - The 4 products are summed and sign-extended to 32 bits.
  - The accumulator and bias add wrap modulo 2^32.
- start is ignored outside IDLE, including in the DONE cycle. cfg_* changes after capture have no effect.
- Reset values: state IDLE; busy, done, in_rd_en, k_rd_en, out_wr_valid all 0; addresses and out_wr_data 0.
- Reset in any state returns to IDLE on the next edge. No further strobes or writes occur, and the accumulator is cleared.

## Timing
- start sampled at edge E0; cycle 1 is the first RUN cycle, with busy=1.
- Read latency:
  - Address is driven in RUN cycle t; RAM data is valid in cycle t+1.
  - The 4-lane product is registered at the end of t+1 and accumulated at the end of t+2.
- Per output, with ready=1: 8G RUN + 2 DRAIN + 1 WRITE = 8G+3 cycles.
- done is high in cycle len*(8G+3)+1 after E0. With len=0 or G=0, done is high in cycle 1 and no reads or writes occur.
- With out_wr_ready=0, WRITE holds. out_wr_valid, addr and data stay stable, and each stall cycle adds one cycle of latency.
- busy falls in the DONE cycle.

## Configuration
- CONV1D_SEQ_RELU_EN:
  - Defined: out_wr_data = max(acc+bias, 0); any negative result is written as 0.
  - Undefined: raw wrapped acc+bias is written.
  - Cycle timing is identical either way.

## Test plan
- len=1, ch=4, all inputs 0x01010101, all weights 0x01010101, offset 0, bias 0 -> single write addr 0, data 4; done at cycle 12.
- len=8, ch=4, same data -> outputs p0..p7 = 16,20,24,28,32,28,24,20; out-of-range taps produce no read strobes.
- len=2, ch=4, inputs 0x80808080, offset 128, weights 0x05050505, bias -7 -> both outputs 0xFFFFFFF9. With CONV1D_SEQ_RELU_EN defined -> both outputs 0.
- len=2, ch=4, out_wr_ready held low 5 cycles at the first WRITE -> valid/addr/data stable through the stall; done 5 cycles later than nominal.
- reset asserted mid-RUN -> busy=0 and no strobes the next cycle, no out_wr_valid; a following start with len=1 completes normally.
- start with len=0 -> done at cycle 1, no writes; start pulsed while busy -> ignored, cycle count unchanged.

Source files
------------

// File: rtl/conv1d_sequencer.sv
// conv1d_sequencer: kernel-8, pad-4 1-D convolution sequencer over the CFU word buffers.
// Optional build macro CONV1D_SEQ_RELU_EN clamps negative results to zero at the write port.
module conv1d_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] cfg_len,
  input  logic [7:0]  cfg_ch,
  input  logic [31:0] cfg_bias,
  input  logic [8:0]  cfg_input_offset,
  output logic        busy,
  output logic        done,
  output logic        in_rd_en,
  output logic [14:0] in_rd_addr,
  input  logic [31:0] in_rd_data,
  output logic        k_rd_en,
  output logic [7:0]  k_rd_addr,
  input  logic [31:0] k_rd_data,
  output logic        out_wr_valid,
  input  logic        out_wr_ready,
  output logic [9:0]  out_wr_addr,
  output logic [31:0] out_wr_data
);
  localparam logic [10:0] MAX_LEN    = 11'd1024;
  localparam logic [5:0]  MAX_GROUPS = 6'd32;
  localparam logic [2:0]  LAST_TAP   = 3'd7;
  localparam logic [11:0] PADDING    = 12'd4;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_WRITE, S_DONE} state_t;
  state_t r_state, w_state_next;

  logic [10:0]        r_len;
  logic [5:0]         r_groups;
  logic [31:0]        r_bias;
  logic [8:0]         r_offset;
  logic [9:0]         r_p;
  logic [2:0]         r_k;
  logic [4:0]         r_g;
  logic               r_drain;
  logic               r_tap_v;
  logic signed [19:0] r_prod;
  logic [31:0]        r_acc;

  logic [10:0] w_len_eff;
  logic [5:0]  w_groups_eff;
  logic [11:0] w_row;
  logic        w_in_range;
  logic        w_last_slot;
  logic        w_last_pos;
  logic [31:0] w_sum;
  logic [31:0] w_result;

  assign w_len_eff    = (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
  // A channel count of 128 or more saturates at the buffer row width.
  assign w_groups_eff = (cfg_ch >= 8'd128) ? MAX_GROUPS : 6'(cfg_ch >> 2);

  // row = p + k - 4 in 12-bit two's complement; bit 11 flags the left pad.
  assign w_row       = {2'b00, r_p} + {9'b0, r_k} - PADDING;
  assign w_in_range  = !w_row[11] && (w_row[10:0] < r_len);
  assign w_last_slot = (r_k == LAST_TAP) && ({1'b0, r_g} == r_groups - 6'd1);
  assign w_last_pos  = ({1'b0, r_p} == r_len - 11'd1);

  logic signed [17:0] w_lane_prod [4];
  logic signed [19:0] w_lane_sum;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic signed [9:0] w_act;
    logic signed [7:0] w_wgt;
    assign w_act = $signed({{2{in_rd_data[31-8*gi]}}, in_rd_data[31-8*gi -: 8]})
                 + $signed({r_offset[8], r_offset});
    assign w_wgt = $signed(k_rd_data[31-8*gi -: 8]);
    assign w_lane_prod[gi] = 18'(w_act) * 18'(w_wgt);
  end

  assign w_lane_sum = 20'(w_lane_prod[0]) + 20'(w_lane_prod[1])
                    + 20'(w_lane_prod[2]) + 20'(w_lane_prod[3]);

  assign w_sum = r_acc + r_bias;
`ifdef CONV1D_SEQ_RELU_EN
  assign w_result = w_sum[31] ? 32'd0 : w_sum;
`else
  assign w_result = w_sum;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    in_rd_en     = 1'b0;
    k_rd_en      = 1'b0;
    in_rd_addr   = '0;
    k_rd_addr    = '0;
    out_wr_valid = 1'b0;
    out_wr_addr  = '0;
    out_wr_data  = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = (w_len_eff == 11'd0 || w_groups_eff == 6'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_in_range) begin
          in_rd_en   = 1'b1;
          k_rd_en    = 1'b1;
          in_rd_addr = {w_row[9:0], r_g};
          k_rd_addr  = {r_k, r_g};
        end
        if (w_last_slot) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (r_drain) w_state_next = S_WRITE;
      end
      S_WRITE: begin
        busy         = 1'b1;
        out_wr_valid = 1'b1;
        out_wr_addr  = r_p;
        out_wr_data  = w_result;
        if (out_wr_ready) w_state_next = w_last_pos ? S_DONE : S_RUN;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Out-of-range slots push a zero product so the accumulate stage never needs gating.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len    <= '0;
      r_groups <= '0;
      r_bias   <= '0;
      r_offset <= '0;
      r_p      <= '0;
      r_k      <= '0;
      r_g      <= '0;
      r_drain  <= 1'b0;
      r_tap_v  <= 1'b0;
      r_prod   <= '0;
      r_acc    <= '0;
    end else begin
      r_tap_v <= (r_state == S_RUN) && w_in_range;
      r_prod  <= r_tap_v ? w_lane_sum : 20'sd0;
      r_acc   <= r_acc + {{12{r_prod[19]}}, r_prod};
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len    <= w_len_eff;
            r_groups <= w_groups_eff;
            r_bias   <= cfg_bias;
            r_offset <= cfg_input_offset;
            r_p      <= '0;
            r_k      <= '0;
            r_g      <= '0;
            r_acc    <= '0;
          end
        end
        S_RUN: begin
          r_drain <= 1'b0;
          r_k     <= r_k + 3'd1;
          if (r_k == LAST_TAP) r_g <= w_last_slot ? 5'd0 : r_g + 5'd1;
        end
        S_DRAIN: r_drain <= 1'b1;
        S_WRITE: begin
          if (out_wr_ready) begin
            r_acc <= '0;
            if (!w_last_pos) r_p <= r_p + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
